pv_sampler: RTL and testbench

Serial ADC front end for the PID datapath. It periodically reads one BITS-wide sample from an external SPI-style ADC and presents it on `pv` with a one-cycle `pv_stb`. The `pv`/`pv_stb` outputs connect directly to the `pv`/`pv_stb` inputs of the `pid` block, so each completed conversion advances the PID integrator exactly once.

---
 rtl/pv_sampler_if.sv | 18 +
 rtl/pv_sampler.sv | 187 ++++++++++++++++++
 tb/tb_pv_sampler.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pv_sampler_if.sv
// ADC serial bus between pv_sampler (master) and an SPI-style ADC (slave).
interface pv_sampler_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_miso;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        input  adc_miso
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        output adc_miso
    );
endinterface

// File: rtl/pv_sampler.sv
// Periodic SPI-style ADC reader feeding the pid process value with a one-cycle strobe.
// Optional build macro PV_SAMPLER_AVG_EN turns pv into a 4-sample moving average.
module pv_sampler #(
    parameter int unsigned BITS   = 8,
    parameter int unsigned DIV    = 4,
    parameter int unsigned PERIOD = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    pv_sampler_if.master     adc,
    output logic [BITS-1:0]  pv,
    output logic             pv_stb,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            sclk_q, sclk_d;
    logic            cs_n_q, cs_n_d;
    logic [BITS-1:0] shreg_q, shreg_d;
    logic [BITS-1:0] shift_in;
    logic [BITS-1:0] pv_q, pv_new;
    logic            overrun_q, overrun_d;
    logic            tick;
    logic            load;

    assign tick     = en && (timer_q == TIMER_LAST);
    assign shift_in = BITS'({shreg_q, adc.adc_miso});

    always_comb begin
        timer_d = timer_q;
        if (!en || timer_q == TIMER_LAST) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        shreg_d = shreg_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    shreg_d = shift_in;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        // Final falling edge ends the frame and publishes the sample.
                        if (bit_q == BIT_LAST) begin
                            state_d = S_DONE;
                            cs_n_d  = 1'b1;
                            load    = 1'b1;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        sclk_d  = 1'b1;
                        shreg_d = shift_in;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (!en) begin
            overrun_d = 1'b0;
        end else if (tick && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            shreg_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            shreg_q   <= shreg_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PV_SAMPLER_AVG_EN
    logic [BITS-1:0] hist0_q, hist1_q, hist2_q;
    logic            primed_q;
    logic [BITS+1:0] avg_sum;

    assign avg_sum = {2'b00, shreg_q} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
    // Before the first sample the history is meaningless, so pass the raw value through.
    assign pv_new  = primed_q ? BITS'(avg_sum >> 2) : shreg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist0_q  <= '0;
            hist1_q  <= '0;
            hist2_q  <= '0;
            primed_q <= 1'b0;
        end else if (load) begin
            primed_q <= 1'b1;
            hist0_q  <= shreg_q;
            hist1_q  <= primed_q ? hist0_q : shreg_q;
            hist2_q  <= primed_q ? hist1_q : shreg_q;
        end
    end
`else
    assign pv_new = shreg_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q <= '0;
        end else if (load) begin
            pv_q <= pv_new;
        end
    end

    assign adc.adc_cs_n = cs_n_q;
    assign adc.adc_sclk = sclk_q;
    assign pv           = pv_q;
    assign pv_stb       = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pv_sampler.sv
// Self-checking bench for pv_sampler: randomized ADC words against a sample-history model.
module tb_pv_sampler;

    localparam int BITS     = 8;
    localparam int DIV      = 4;
    localparam int PERIOD   = 1000;
    localparam int PERIOD_B = 50;
    localparam int FRAME    = 2 * BITS * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            en, en_b;
    logic [BITS-1:0] pv, pv_b;
    logic            pv_stb, pv_stb_b, busy, busy_b, overrun, overrun_b;

    pv_sampler_if adc_a ();
    pv_sampler_if adc_b ();

    pv_sampler #(.BITS(BITS), .DIV(DIV), .PERIOD(PERIOD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .adc     (adc_a),
        .pv      (pv),
        .pv_stb  (pv_stb),
        .busy    (busy),
        .overrun (overrun)
    );

    pv_sampler #(.BITS(BITS), .DIV(DIV), .PERIOD(PERIOD_B)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en_b),
        .adc     (adc_b),
        .pv      (pv_b),
        .pv_stb  (pv_stb_b),
        .busy    (busy_b),
        .overrun (overrun_b)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: word latched at chip-select fall, MSB first, next bit after each SCLK rise.
    logic [BITS-1:0] adc_next;
    logic [BITS-1:0] adc_word;
    int              rise_idx = 0;
    logic [BITS-1:0] pending[$];
    logic [BITS-1:0] hist[$];

    always @(negedge adc_a.adc_cs_n) begin
        adc_word = adc_next;
        adc_next = BITS'($urandom_range(1, (1 << BITS) - 1));
        rise_idx = 0;
        pending.push_back(adc_word);
    end
    always @(posedge adc_a.adc_sclk) rise_idx++;
    assign adc_a.adc_miso = (rise_idx < BITS) ? adc_word[BITS-1-rise_idx] : 1'b0;
    assign adc_b.adc_miso = 1'b0;

    // Reference: pv is the mean of the last four completed samples, padding a short
    // history with copies of the very first sample.
    function automatic logic [BITS-1:0] model_pv();
        logic [BITS+1:0] s;
        int              idx;
`ifdef PV_SAMPLER_AVG_EN
        s = '0;
        for (int i = 0; i < 4; i++) begin
            idx = hist.size() - 1 - i;
            s = s + ((idx >= 0) ? {2'b00, hist[idx]} : {2'b00, hist[0]});
        end
        return BITS'(s / 4);
`else
        s   = '0;
        idx = 0;
        return hist[hist.size()-1];
`endif
    endfunction

    int              stb_cyc_q[$];
    logic [BITS-1:0] stb_val_q[$];
    logic [BITS-1:0] exp_val_q[$];
    int              csfall_q[$];
    int              csrise_q[$];
    int              rises_q[$];
    int              stb_b_cyc_q[$];
    int              rises_cur = 0;
    logic            prev_cs   = 1'b1;
    logic            prev_sclk = 1'b0;

    always @(negedge clk) begin
        logic [BITS-1:0] w;
        if (prev_cs && !adc_a.adc_cs_n) begin
            csfall_q.push_back(cyc);
            rises_cur = 0;
        end
        if (!prev_cs && adc_a.adc_cs_n && reset_n) begin
            csrise_q.push_back(cyc);
            rises_q.push_back(rises_cur);
        end
        if (!adc_a.adc_cs_n && adc_a.adc_sclk && !prev_sclk) rises_cur++;
        if (pv_stb === 1'b1) begin
            w = (pending.size() > 0) ? pending.pop_front() : 'x;
            hist.push_back(w);
            stb_cyc_q.push_back(cyc);
            stb_val_q.push_back(pv);
            exp_val_q.push_back(model_pv());
        end
        if (pv_stb_b === 1'b1) stb_b_cyc_q.push_back(cyc);
        prev_cs   = adc_a.adc_cs_n;
        prev_sclk = adc_a.adc_sclk;
    end

    task automatic clear_obs();
        stb_cyc_q.delete(); stb_val_q.delete(); exp_val_q.delete();
        csfall_q.delete(); csrise_q.delete(); rises_q.delete(); stb_b_cyc_q.delete();
    endtask

    task automatic wait_count(input int which, input int n, input int budget, output bit ok);
        int sz;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            case (which)
                0:       sz = stb_cyc_q.size();
                1:       sz = stb_b_cyc_q.size();
                2:       sz = csfall_q.size();
                default: sz = rises_cur;
            endcase
            if (sz >= n) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        en_b    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (adc_a.adc_cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", adc_a.adc_cs_n); else passed++;
        checks++; if (adc_a.adc_sclk !== 1'b0) $display("FAIL reset_sclk got %b want 0", adc_a.adc_sclk); else passed++;
        checks++; if (pv !== '0) $display("FAIL reset_pv got %h want 0", pv); else passed++;
        checks++; if (pv_stb !== 1'b0) $display("FAIL reset_stb got %b want 0", pv_stb); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        pending.delete();
        hist.delete();
        clear_obs();
    endtask

    task automatic test_raw_read();
        int en_cyc;
        bit ok;
        clear_obs();
        adc_next = 8'hA5;
        @(negedge clk);
        en     = 1'b1;
        en_cyc = cyc;
        wait_count(0, 1, PERIOD + 200, ok);
        en = 1'b0;
        checks++;
        if (!ok) begin
            $display("FAIL raw_timeout got no strobe want strobe");
            return;
        end
        passed++;
        checks++; if (stb_cyc_q[0] != en_cyc + PERIOD + FRAME)
            $display("FAIL raw_latency got %0d want %0d", stb_cyc_q[0] - en_cyc, PERIOD + FRAME); else passed++;
        checks++; if (stb_val_q[0] !== 8'hA5) $display("FAIL raw_pv got %h want a5", stb_val_q[0]); else passed++;
        checks++; if (csrise_q.size() < 1 || csrise_q[0] - csfall_q[0] != FRAME)
            $display("FAIL raw_cs_low got %0d want %0d",
                     (csrise_q.size() < 1) ? -1 : csrise_q[0] - csfall_q[0], FRAME); else passed++;
        checks++; if (rises_q.size() < 1 || rises_q[0] != BITS)
            $display("FAIL raw_sclk_rises got %0d want %0d",
                     (rises_q.size() < 1) ? -1 : rises_q[0], BITS); else passed++;
        @(negedge clk); #1;
        checks++; if (pv_stb !== 1'b0) $display("FAIL raw_stb_width got %b want 0", pv_stb); else passed++;
        checks++; if (pv !== 8'hA5) $display("FAIL raw_pv_hold got %h want a5", pv); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL raw_overrun got %b want 0", overrun); else passed++;
    endtask

    task automatic test_periodic();
        bit ok;
        clear_obs();
        @(negedge clk);
        en = 1'b1;
        wait_count(0, 4, 5 * PERIOD, ok);
        checks++;
        if (!ok) begin
            en = 1'b0;
            $display("FAIL periodic_timeout got %0d strobes want 4", stb_cyc_q.size());
            return;
        end
        passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL periodic_overrun got %b want 0", overrun); else passed++;
        en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++; if (stb_cyc_q[i] - stb_cyc_q[i-1] != PERIOD)
                $display("FAIL periodic_spacing[%0d] got %0d want %0d", i,
                         stb_cyc_q[i] - stb_cyc_q[i-1], PERIOD); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (stb_val_q[i] !== exp_val_q[i])
                $display("FAIL periodic_pv[%0d] got %h want %h", i, stb_val_q[i], exp_val_q[i]); else passed++;
        end
    endtask

    task automatic test_overrun();
        bit ok;
        clear_obs();
        @(negedge clk);
        en_b = 1'b1;
        wait_count(1, 3, 8 * PERIOD_B, ok);
        checks++;
        if (!ok) begin
            en_b = 1'b0;
            $display("FAIL overrun_timeout got %0d strobes want 3", stb_b_cyc_q.size());
            return;
        end
        passed++;
        // A conversion outlasts PERIOD_B, so every second tick is dropped.
        for (int i = 1; i < 3; i++) begin
            checks++; if (stb_b_cyc_q[i] - stb_b_cyc_q[i-1] != 2 * PERIOD_B)
                $display("FAIL overrun_spacing[%0d] got %0d want %0d", i,
                         stb_b_cyc_q[i] - stb_b_cyc_q[i-1], 2 * PERIOD_B); else passed++;
        end
        checks++; if (overrun_b !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun_b); else passed++;
        @(negedge clk);
        en_b = 1'b0;
        @(negedge clk); #1;
        checks++; if (overrun_b !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun_b); else passed++;
        repeat (2 * PERIOD_B) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        @(negedge clk);
        en = 1'b1;
        wait_count(3, 3, PERIOD + 200, ok);
        checks++;
        if (!ok) begin
            en = 1'b0;
            $display("FAIL resetmid_timeout got %0d rises want 3", rises_cur);
            return;
        end
        passed++;
        reset_n = 1'b0;
        #1;
        checks++; if (adc_a.adc_cs_n !== 1'b1) $display("FAIL resetmid_cs_n got %b want 1", adc_a.adc_cs_n); else passed++;
        checks++; if (adc_a.adc_sclk !== 1'b0) $display("FAIL resetmid_sclk got %b want 0", adc_a.adc_sclk); else passed++;
        checks++; if (pv !== '0) $display("FAIL resetmid_pv got %h want 0", pv); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL resetmid_busy got %b want 0", busy); else passed++;
        en = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pending.delete();
        hist.delete();
        repeat (FRAME + 20) @(negedge clk);
        checks++; if (stb_cyc_q.size() != 0) $display("FAIL resetmid_no_stb got %0d strobes want 0", stb_cyc_q.size()); else passed++;
    endtask

    task automatic test_en_drop();
        bit ok;
        clear_obs();
        @(negedge clk);
        en = 1'b1;
        wait_count(2, 1, PERIOD + 50, ok);
        checks++;
        if (!ok) begin
            en = 1'b0;
            $display("FAIL endrop_timeout got no cs fall want cs fall");
            return;
        end
        passed++;
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_count(0, 1, FRAME + 20, ok);
        checks++;
        if (!ok) begin
            $display("FAIL endrop_stb got no strobe want strobe");
            return;
        end
        passed++;
        checks++; if (stb_cyc_q[0] - csfall_q[0] != FRAME)
            $display("FAIL endrop_latency got %0d want %0d", stb_cyc_q[0] - csfall_q[0], FRAME); else passed++;
        checks++; if (stb_val_q[0] !== exp_val_q[0])
            $display("FAIL endrop_pv got %h want %h", stb_val_q[0], exp_val_q[0]); else passed++;
        repeat (2 * PERIOD) @(negedge clk);
        checks++; if (csfall_q.size() != 1) $display("FAIL endrop_quiet got %0d cs falls want 1", csfall_q.size()); else passed++;
    endtask

    initial begin
        adc_next = BITS'($urandom_range(1, (1 << BITS) - 1));
        test_reset();
        test_raw_read();
        test_periodic();
        test_overrun();
        test_reset_mid();
        test_en_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
